// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: request/ready instruction-memory fetch port.
interface pc_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register with IDLE/FETCH/EXEC sequencing and next-PC adder.
// Define PC_MISALIGN_TRAP_EN to redirect targets with bit 1 set to TRAP_VEC and pulse trap.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCAsrc,
  input  logic             PCBsrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  input  logic             commit,
  input  logic             stall,
  pc_fetch_unit_if.master  imem,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             trap
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t      state, state_next;
  logic        go, trap_hit;
  logic [31:0] sum, tgt, next_pc;
  always_comb begin
    go = state == EXEC && commit && !stall;
    state_next = state == IDLE ? FETCH :
                 state == FETCH ? (imem.ready ? EXEC : FETCH) :
                 (go ? FETCH : EXEC);
    imem.req = state == FETCH;
    imem.addr = pc;
    instr_valid = state == EXEC;
    pc_plus4 = pc + 32'd4;
    sum = (PCAsrc ? imm : 32'd4) + (PCBsrc ? rs1 : pc);
    tgt = {sum[31:1], sum[0] & ~PCBsrc};
`ifdef PC_MISALIGN_TRAP_EN
    trap_hit = go && tgt[1];
    next_pc = tgt;
`else
    trap_hit = 1'b0;
    next_pc = tgt & ~32'h2;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // trap is a one-cycle pulse; in the default build its input is constant 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      instr <= 32'h0000_0013;
      trap <= 1'b0;
    end else begin
      trap <= trap_hit;
      if (go) pc <= trap_hit ? TRAP_VEC : next_pc;
      if (state == FETCH && imem.ready) instr <= imem.rdata;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus randomized checks against a per-cycle reference model.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCAsrc = 1'b0, PCBsrc = 1'b0, commit = 1'b0, stall = 1'b0;
  logic [31:0] imm = '0, rs1 = '0;
  logic [31:0] pc, pc_plus4, instr;
  logic        instr_valid, trap;
  int          passed = 0, total = 0;
  int          m_phase;
  logic [31:0] m_pc, m_instr;
  logic        m_trap;

  always #5 clk = ~clk;

  pc_fetch_unit_if imem();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .PCAsrc(PCAsrc), .PCBsrc(PCBsrc), .imm(imm), .rs1(rs1),
    .commit(commit), .stall(stall), .imem(imem), .pc(pc), .pc_plus4(pc_plus4),
    .instr(instr), .instr_valid(instr_valid), .trap(trap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc = RESET_PC;
    m_instr = 32'h0000_0013;
    m_trap = 1'b0;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_req"}, 32'(imem.req), 32'(m_phase == 1));
    if (m_phase == 1) chk({tag, "_addr"}, imem.addr, m_pc);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_pc_plus4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, "_valid"}, 32'(instr_valid), 32'(m_phase == 2));
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_trap"}, 32'(trap), 32'(m_trap));
  endtask

  // phase 0 = idle, 1 = fetching, 2 = executing
  task automatic cycle();
    logic [31:0] s;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_trap = 1'b0;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (imem.ready) begin
          m_instr = imem.rdata;
          m_phase = 2;
        end
      end else if (commit && !stall) begin
        s = (PCAsrc ? imm : 32'd4) + (PCBsrc ? rs1 : m_pc);
        if (PCBsrc) s[0] = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        if (s[1]) begin
          m_pc = TRAP_VEC;
          m_trap = 1'b1;
        end else m_pc = s;
`else
        s[1] = 1'b0;
        m_pc = s;
`endif
        m_phase = 1;
      end
    end
    #1 compare("cyc");
  endtask

  task automatic go_exec();
    imem.ready = 1'b1;
    imem.rdata = $urandom;
    for (int k = 0; k < 4 && m_phase != 2; k++) cycle();
    imem.ready = 1'b0;
    chk("in_exec", 32'(instr_valid), 32'd1);
  endtask

  task automatic commit_with(input logic a, input logic b, input logic [31:0] i, input logic [31:0] r);
    PCAsrc = a;
    PCBsrc = b;
    imm = i;
    rs1 = r;
    commit = 1'b1;
    stall = 1'b0;
    cycle();
    commit = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("arst_req", 32'(imem.req), 32'd0);
    chk("arst_pc", pc, RESET_PC);
    compare("arst");
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    imem.ready = 1'b1;
    imem.rdata = 32'h00A0_0093;
    cycle();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_req", 32'(imem.req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("t1_req", 32'(imem.req), 32'd1);
    chk("t1_addr", imem.addr, 32'h0);
    cycle();
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h00A0_0093);
    imem.ready = 1'b0;
    commit_with(1'b0, 1'b1, 32'h0, 32'h0000_00FC);
    chk("t2_pc100", pc, 32'h100);
    go_exec();
    commit_with(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_addr", imem.addr, 32'h104);
    chk("t2_plus4", pc_plus4, 32'h108);
    go_exec();
    commit_with(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("t2_neg_imm", pc, 32'hF4);
    go_exec();
    commit_with(1'b1, 1'b0, 32'h0000_010C, 32'h0);
    chk("t3_pc200", pc, 32'h200);
    go_exec();
    commit_with(1'b1, 1'b1, 32'h4, 32'h1001);
    chk("t3_jalr", pc, 32'h1004);
    go_exec();
    PCAsrc = 1'b0;
    PCBsrc = 1'b0;
    commit = 1'b1;
    stall = 1'b1;
    repeat (3) begin
      cycle();
      chk("t4_hold", pc, 32'h1004);
    end
    stall = 1'b0;
    cycle();
    commit = 1'b0;
    chk("t4_update", pc, 32'h1008);
    repeat (5) begin
      cycle();
      chk("t4_req", 32'(imem.req), 32'd1);
      chk("t4_addr", imem.addr, 32'h1008);
    end
    go_exec();
    commit_with(1'b0, 1'b1, 32'h0, 32'hFFFF_FFF8);
    chk("t5_top", pc, 32'hFFFF_FFFC);
    go_exec();
    commit_with(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_wrap", pc, 32'h0);
    go_exec();
    commit_with(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_pc4", pc, 32'h4);
    cycle();
    async_reset();
    cycle();
    go_exec();
    commit_with(1'b0, 1'b1, 32'h0, 32'h302);
`ifdef PC_MISALIGN_TRAP_EN
    chk("t6_pc", pc, 32'h100);
    chk("t6_trap", 32'(trap), 32'd1);
`else
    chk("t6_pc", pc, 32'h304);
    chk("t6_trap", 32'(trap), 32'd0);
`endif
    cycle();
    chk("t6_trap_end", 32'(trap), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      imem.ready = 1'($urandom_range(0, 1));
      imem.rdata = $urandom;
      commit = $urandom_range(0, 2) != 0;
      stall = $urandom_range(0, 3) == 0;
      PCAsrc = 1'($urandom_range(0, 1));
      PCBsrc = 1'($urandom_range(0, 1));
      imm = $urandom;
      rs1 = $urandom;
      if ($urandom_range(0, 199) == 0) async_reset();
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
